// File: rtl/sevenseg_pkg.sv
// Seven-segment constants shared by the display encoder and the capture path.
// Cathode patterns are active-low, bit0 = segment a ... bit6 = segment g.
package sevenseg_pkg;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [3:0] NIB_BLANK = 4'hF;
  localparam logic [3:0] NIB_ERR   = 4'hE;

  typedef enum logic {
    ST_WAIT_STABLE = 1'b0,
    ST_CAPTURED    = 1'b1
  } cap_state_e;

endpackage

// File: rtl/sevenseg_decode.sv
// Combinational cathode-pattern to BCD lookup; zero latency, no flow control.
// Unknown patterns give NIB_ERR with valid low.
module sevenseg_decode
  import sevenseg_pkg::*;
(
  input  logic [6:0] pattern,
  output logic [3:0] nibble,
  output logic       valid
);

  always_comb begin
    nibble = NIB_ERR;
    valid  = 1'b1;
    case (pattern)
      SEG_0:     nibble = 4'd0;
      SEG_1:     nibble = 4'd1;
      SEG_2:     nibble = 4'd2;
      SEG_3:     nibble = 4'd3;
      SEG_4:     nibble = 4'd4;
      SEG_5:     nibble = 4'd5;
      SEG_6:     nibble = 4'd6;
      SEG_7:     nibble = 4'd7;
      SEG_8:     nibble = 4'd8;
      SEG_9:     nibble = 4'd9;
      SEG_BLANK: nibble = NIB_BLANK;
      default:   valid  = 1'b0;
    endcase
  end

endmodule

// File: rtl/sevenseg_capture.sv
// Rebuilds four-digit frames from the multiplexed display bus; results one cycle after the sample, no backpressure.
// SEVENSEG_CAPTURE_TIMEOUT_EN adds the frame timeout counter driving stale.
module sevenseg_capture
  import sevenseg_pkg::*;
#(
  parameter int SETTLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] cathodes,
  input  logic [7:0] anodes,
  output logic [3:0] digit0,
  output logic [3:0] digit1,
  output logic [3:0] digit2,
  output logic [3:0] digit3,
  output logic       frame_valid,
  output logic       seg_err,
  output logic       anode_err,
  output logic       stale
);

  localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] SETTLE_MAX = CNT_W'(SETTLE_CYCLES - 1);

  if (SETTLE_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_params
    $error("sevenseg_capture: SETTLE_CYCLES and TIMEOUT_CYCLES must be >= 1");
  end

  cap_state_e       state_q, state_d;
  logic [7:0]       anodes_q, anodes_d;
  logic [CNT_W-1:0] settle_q, settle_d;
  logic [3:0]       seen_q, seen_d;
  logic [3:0][3:0]  shadow_q, shadow_d;
  logic [3:0][3:0]  digits_q, digits_d;
  logic             frame_valid_q, frame_valid_d;
  logic             seg_err_q, seg_err_d;
  logic             anode_err_q, anode_err_d;

  logic [3:0] dec_nib;
  logic       dec_vld;
  logic       anodes_changed;
  logic       anode_legal;
  logic [3:0] digit_sel;

  sevenseg_decode u_decode (
    .pattern (cathodes),
    .nibble  (dec_nib),
    .valid   (dec_vld)
  );

  always_comb begin
    anodes_d       = anodes;
    anodes_changed = (anodes != anodes_q);
    digit_sel      = ~anodes[3:0];
    anode_legal    = (anodes[7:4] == 4'hF) &&
                     (anodes[3:0] inside {4'hE, 4'hD, 4'hB, 4'h7});

    // Counter saturates so a long dwell in CAPTURED cannot wrap into a second sample.
    if (anodes_changed) begin
      settle_d = '0;
    end else if (settle_q == SETTLE_MAX) begin
      settle_d = settle_q;
    end else begin
      settle_d = settle_q + CNT_W'(1);
    end

    state_d       = state_q;
    seen_d        = seen_q;
    shadow_d      = shadow_q;
    digits_d      = digits_q;
    frame_valid_d = 1'b0;
    seg_err_d     = 1'b0;
    anode_err_d   = 1'b0;

    case (state_q)
      ST_WAIT_STABLE: begin
        if (!anodes_changed && settle_q == SETTLE_MAX) begin
          state_d = ST_CAPTURED;
          if (!anode_legal) begin
            anode_err_d = 1'b1;
          end else begin
            seg_err_d = !dec_vld;
            for (int i = 0; i < 4; i++) begin
              if (digit_sel[i]) begin
                shadow_d[i] = dec_nib;
              end
            end
            seen_d = seen_q | digit_sel;
            if (seen_d == 4'hF) begin
              digits_d      = shadow_d;
              frame_valid_d = 1'b1;
              seen_d        = '0;
            end
          end
        end
      end
      ST_CAPTURED: begin
        if (anodes_changed) begin
          state_d = ST_WAIT_STABLE;
        end
      end
      default: state_d = ST_WAIT_STABLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_WAIT_STABLE;
      anodes_q      <= 8'hFF;
      settle_q      <= '0;
      seen_q        <= '0;
      shadow_q      <= {4{NIB_BLANK}};
      digits_q      <= {4{NIB_BLANK}};
      frame_valid_q <= 1'b0;
      seg_err_q     <= 1'b0;
      anode_err_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      anodes_q      <= anodes_d;
      settle_q      <= settle_d;
      seen_q        <= seen_d;
      shadow_q      <= shadow_d;
      digits_q      <= digits_d;
      frame_valid_q <= frame_valid_d;
      seg_err_q     <= seg_err_d;
      anode_err_q   <= anode_err_d;
    end
  end

  assign digit0      = digits_q[0];
  assign digit1      = digits_q[1];
  assign digit2      = digits_q[2];
  assign digit3      = digits_q[3];
  assign frame_valid = frame_valid_q;
  assign seg_err     = seg_err_q;
  assign anode_err   = anode_err_q;

`ifdef SEVENSEG_CAPTURE_TIMEOUT_EN
  localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT_CYCLES - 1);

  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            stale_q, stale_d;

  // stale is sticky from reset until the next frame, independent of counter value.
  always_comb begin
    to_cnt_d = to_cnt_q;
    stale_d  = stale_q;
    if (frame_valid_d) begin
      to_cnt_d = '0;
      stale_d  = 1'b0;
    end else if (to_cnt_q == TO_MAX) begin
      stale_d = 1'b1;
    end else begin
      to_cnt_d = to_cnt_q + TO_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      to_cnt_q <= '0;
      stale_q  <= 1'b1;
    end else begin
      to_cnt_q <= to_cnt_d;
      stale_q  <= stale_d;
    end
  end

  assign stale = stale_q;
`else
  assign stale = 1'b0;
`endif

endmodule

// File: tb/tb_sevenseg_capture.sv
// Randomized bench for sevenseg_capture against a dwell-level model of the capture rules.
module tb_sevenseg_capture;

  localparam int SETTLE  = 4;
  localparam int TIMEOUT = 100;

  logic       clk;
  logic       reset;
  logic [6:0] cathodes;
  logic [7:0] anodes;
  logic [3:0] digit0, digit1, digit2, digit3;
  logic       frame_valid, seg_err, anode_err, stale;

  sevenseg_capture #(
    .SETTLE_CYCLES  (SETTLE),
    .TIMEOUT_CYCLES (TIMEOUT)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .cathodes    (cathodes),
    .anodes      (anodes),
    .digit0      (digit0),
    .digit1      (digit1),
    .digit2      (digit2),
    .digit3      (digit3),
    .frame_valid (frame_valid),
    .seg_err     (seg_err),
    .anode_err   (anode_err),
    .stale       (stale)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [6:0] seg_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                               7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
  logic [7:0] bad_tab [6]  = '{8'hFF, 8'hFC, 8'hEF, 8'h00, 8'h7E, 8'hF5};

  int         n_checks = 0;
  int         n_errors = 0;
  bit         seen_m   [4];
  int         shadow_m [4];
  int         digits_m [4];
  logic [7:0] last_an;
  int         age;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int seg2nib(input logic [6:0] c);
    if (c == 7'h7F) return 15;
    for (int d = 0; d < 10; d++) if (seg_tab[d] == c) return d;
    return 14;
  endfunction

  function automatic logic [15:0] pack_digits();
    logic [15:0] p;
    for (int i = 0; i < 4; i++) p[i*4 +: 4] = 4'(digits_m[i]);
    return p;
  endfunction

  function automatic logic exp_stale();
`ifdef SEVENSEG_CAPTURE_TIMEOUT_EN
    return (age < 0) || (age >= TIMEOUT);
`else
    return 1'b0;
`endif
  endfunction

  task automatic do_reset();
    anodes   = 8'hFF;
    cathodes = 7'h7F;
    reset    = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      seen_m[i]   = 1'b0;
      shadow_m[i] = 15;
      digits_m[i] = 15;
    end
    last_an = 8'hFF;
    age     = -1;
    check_eq("rst_digits", {digit3, digit2, digit1, digit0}, 16'hFFFF);
    check_eq("rst_frame_valid", frame_valid, 1'b0);
    check_eq("rst_seg_err", seg_err, 1'b0);
    check_eq("rst_anode_err", anode_err, 1'b0);
    check_eq("rst_stale", stale, exp_stale());
    reset = 1'b1;
  endtask

  // One anode dwell of len cycles; ca_late replaces the cathodes after the sample point.
  task automatic dwell(input logic [7:0] an, input logic [6:0] ca, input int len,
                       input logic [6:0] ca_late);
    int idx, di, nib;
    bit exp_fv, exp_se, exp_ae, all_seen;
    int n_fv, n_se, n_ae, at_fv, at_se, at_ae;
    logic [15:0] got_dig;
    idx    = (an == last_an) ? SETTLE : SETTLE + 1;
    exp_fv = 0; exp_se = 0; exp_ae = 0;
    n_fv = 0; n_se = 0; n_ae = 0; at_fv = 0; at_se = 0; at_ae = 0;
    got_dig = '0;
    if (len >= idx) begin
      if (an[7:4] != 4'hF || $countones(an[3:0]) != 3) begin
        exp_ae = 1;
      end else begin
        di = 0;
        for (int b = 0; b < 4; b++) if (!an[b]) di = b;
        nib = seg2nib(ca);
        exp_se = (nib == 14);
        seen_m[di]   = 1'b1;
        shadow_m[di] = nib;
        all_seen = seen_m[0] && seen_m[1] && seen_m[2] && seen_m[3];
        if (all_seen) begin
          exp_fv = 1;
          for (int i = 0; i < 4; i++) begin
            digits_m[i] = shadow_m[i];
            seen_m[i]   = 1'b0;
          end
        end
      end
    end
    last_an  = an;
    anodes   = an;
    cathodes = ca;
    for (int k = 1; k <= len; k++) begin
      @(posedge clk);
      #1;
      if (exp_fv && k == idx) age = 0;
      else if (age >= 0) age++;
      if (frame_valid) begin n_fv++; at_fv = k; got_dig = {digit3, digit2, digit1, digit0}; end
      if (seg_err)     begin n_se++; at_se = k; end
      if (anode_err)   begin n_ae++; at_ae = k; end
      check_eq("stale", stale, exp_stale());
      if (k == idx) cathodes = ca_late;
    end
    check_eq("frame_valid_count", n_fv, exp_fv);
    check_eq("seg_err_count", n_se, exp_se);
    check_eq("anode_err_count", n_ae, exp_ae);
    if (exp_fv) begin
      check_eq("frame_valid_cycle", at_fv, idx);
      check_eq("frame_digits", got_dig, pack_digits());
    end
    if (exp_se) check_eq("seg_err_cycle", at_se, idx);
    if (exp_ae) check_eq("anode_err_cycle", at_ae, idx);
    check_eq("digits_hold", {digit3, digit2, digit1, digit0}, pack_digits());
  endtask

  task automatic dw(input logic [7:0] an, input logic [6:0] ca, input int len);
    dwell(an, ca, len, ca);
  endtask

  initial begin
    int r, i, len;
    logic [7:0] an;
    logic [6:0] ca, ca_late;

    reset    = 1'b0;
    anodes   = 8'hFF;
    cathodes = 7'h7F;
    last_an  = 8'hFF;
    age      = -1;
    @(posedge clk);
    #1;
    do_reset();

    // Legal scan 1,2,3,4 on E,D,B,7.
    dw(8'hFE, seg_tab[1], 100); dw(8'hFD, seg_tab[2], 100);
    dw(8'hFB, seg_tab[3], 100); dw(8'hF7, seg_tab[4], 100);

    // Too-short dwell, then a normal scan.
    dw(8'hFE, 7'h24, SETTLE - 1);
    dw(8'hFD, seg_tab[6], 100); dw(8'hFB, seg_tab[7], 100);
    dw(8'hF7, seg_tab[8], 100); dw(8'hFE, seg_tab[9], 100);

    // Bad cathode pattern on digit2.
    dw(8'hFD, seg_tab[2], 100); dw(8'hFB, 7'h55, 100);
    dw(8'hF7, seg_tab[4], 100); dw(8'hFE, seg_tab[1], 100);

    // Illegal anode vectors in the middle of a frame.
    dw(8'hFD, seg_tab[5], 100); dw(8'hF7, seg_tab[6], 100);
    dw(8'hFC, seg_tab[0], 100); dw(8'hEF, seg_tab[0], 100);
    dw(8'hFB, seg_tab[7], 100); dw(8'hFE, seg_tab[8], 100);

    // Reset after two digits discards the partial frame.
    dw(8'hFD, seg_tab[9], 100); dw(8'hFB, seg_tab[0], 100);
    do_reset();
    dw(8'hFE, seg_tab[5], 100); dw(8'hFD, seg_tab[6], 100);
    dw(8'hFB, seg_tab[7], 100); dw(8'hF7, seg_tab[8], 100);

    // Anodes parked at FF from reset, then one frame and a long idle tail.
    do_reset();
    dw(8'hFF, 7'h7F, 150);
    dw(8'hFE, seg_tab[3], 20); dw(8'hFD, seg_tab[1], 20);
    dw(8'hFB, seg_tab[4], 20); dw(8'hF7, seg_tab[1], 130);

    for (int n = 0; n < 120; n++) begin
      r = $urandom_range(0, 19);
      len = $urandom_range(SETTLE + 2, SETTLE + 25);
      r = (r == 19) ? 100 : r;
      if (r == 100) begin
        do_reset();
      end else if (r < 2) begin
        i = $urandom_range(0, 5);
        if (bad_tab[i] == last_an) i = (i + 1) % 6;
        dw(bad_tab[i], 7'($urandom), len);
      end else begin
        i  = $urandom_range(0, 3);
        an = ~(8'h01 << i);
        if (an == last_an) an = ~(8'h01 << ((i + 1) % 4));
        r = $urandom_range(0, 9);
        if (r < 7)       ca = seg_tab[$urandom_range(0, 9)];
        else if (r == 7) ca = 7'h7F;
        else             ca = 7'($urandom);
        ca_late = ($urandom_range(0, 1) == 1) ? 7'($urandom) : ca;
        if ($urandom_range(0, 7) == 0) len = SETTLE - 1;
        dwell(an, ca, len, ca_late);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sevenseg_capture.md
# sevenseg_capture

Receive-side counterpart of the quad seven-segment display driver. Samples the multiplexed active-low cathode/anode bus on the same clock and decodes each lit digit back to a BCD nibble. It reassembles complete four-digit frames and flags malformed segment or anode patterns. It sits beside the display driver, or in the bench, as a self-check and readback path for the timer display.

## Interface
- SETTLE_CYCLES, 4: cycles the anode vector must hold before cathodes are sampled (≥1)
- TIMEOUT_CYCLES, 50000: cycles without a completed frame before `stale` asserts (10 ms at 5 MHz)
- clk  input  1  system clock (5 MHz domain); one clock only
- reset  input  1  asynchronous, active-low reset
- cathodes  input  7  segment drive, active-low, bit0=a … bit6=g, synchronous to clk
- anodes  input  8  digit select, active-low; only [3:0] legal
- digit0..digit3  output  4 each  last complete frame; digit0 = anode bit0 (seconds)
- frame_valid  output  1  one-cycle pulse when digit0..3 update
- seg_err  output  1  one-cycle pulse: sampled cathode pattern not in decode set
- anode_err  output  1  one-cycle pulse: settled anode vector not one-hot-low in [3:0]
- stale  output  1  level: no frame completed within TIMEOUT_CYCLES

## Operation
- Decode set (cathodes hex → nibble): 40→0, 79→1, 24→2, 30→3, 19→4, 12→5, 02→6, 78→7, 00→8, 10→9, 7F (blank)→F; any other → E plus `seg_err`.
- FSM, two states:
  - WAIT_STABLE: settle counter increments while `anodes` equals its previous-cycle value; any change clears it. When it reaches SETTLE_CYCLES−1: legal vector → sample, go to CAPTURED; illegal vector (all high, >1 low, or any of [7:4] low) → pulse `anode_err`, go to CAPTURED without sampling.
  - CAPTURED: hold until `anodes` changes, then clear counter, return to WAIT_STABLE. Exactly one sample or error per anode dwell.
- Sample of digit i: shadow[i] ← decoded nibble, seen[i] ← 1.
- When seen (including the current sample) is 1111: digit0..3 ← shadow (current sample included), pulse `frame_valid`, clear seen. Order of arrival does not matter.
- Repeated sample of an already-seen digit overwrites shadow[i]; frame still completes only when all four are seen.
- Cathode changes within a stable anode dwell are ignored after sampling.
- Reset mid-frame: seen, shadow, FSM, and counters are all cleared; the partial frame is discarded.

## Timing
- Reset values: digit0..3 = F, frame_valid = 0, seg_err = 0, anode_err = 0, stale = 1 (with macro) or 0 (without).
- Sample cycle = the cycle the settle counter reaches SETTLE_CYCLES−1, i.e. SETTLE_CYCLES cycles after the anode change is first registered.
- seg_err and anode_err are registered: they pulse the cycle after the sample cycle.
- digit0..3 update and frame_valid pulse the cycle after the completing sample.
- Dwell shorter than SETTLE_CYCLES: no sample, no error.
- Timeout counter clears on frame_valid and saturates at TIMEOUT_CYCLES−1. `stale` rises the cycle after saturation and falls together with frame_valid.

## Configuration
- SEVENSEG_CAPTURE_TIMEOUT_EN defined: timeout counter, width $clog2(TIMEOUT_CYCLES), and `stale` logic are present.
- Undefined: no counter is built; `stale` is tied to 0. All other behaviour is identical.

## Structure
- Shared package (sevenseg_pkg): the ten digit cathode constants, SEG_BLANK = 7'h7F, NIB_BLANK = 4'hF, NIB_ERR = 4'hE, and the FSM state enum.
- The same package constants serve the display driver's encoder, so both ends use one table.
- One sub-module: sevenseg_decode. It is purely combinational, 7-bit pattern → 4-bit nibble + valid, and holds the lookup.

## Test plan
- Reset, then legal scan of 1,2,3,4 on anodes E,D,B,7 with 100-cycle dwells → after 4th sample+1 cycle: digits 4,3,2,1 (digit0=4? no: digit0 from anode bit0 = 1, digit1 = 2, digit2 = 3, digit3 = 4) and one frame_valid pulse; no errors.
- Dwell of SETTLE_CYCLES−1 on anode E with cathodes 24 → no sample, no frame, no error; next full-dwell scan completes normally.
- Cathodes 7'h55 on anode B within an otherwise legal frame → seg_err pulse; frame completes with digit2 = E.
- Anodes 8'hFC, then 8'hEF, each dwelling 100 cycles → two anode_err pulses; seen unchanged; frame_valid absent.
- Reset asserted after 2 of 4 digits, then a full scan of 5,6,7,8 → exactly one frame_valid; digits 5,6,7,8; no stale digits from before reset.
- With macro, TIMEOUT_CYCLES = 100, anodes held at FF → stale = 1 from reset and stays 1. After a legal frame, stale falls with frame_valid and rises again 100 cycles later if scanning stops.
